// File: rtl/song_sequencer_pkg.sv
// song_sequencer_pkg: note codes, FSM states, ROM entry layout
// and note/LED decode helpers shared by the sequencer and its ROM.
package song_sequencer_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_G    = 4'd5;
  localparam logic [3:0] NOTE_A    = 4'd6;
  localparam logic [3:0] NOTE_B    = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  localparam int CODE_HI = 7;
  localparam int CODE_LO = 4;
  localparam int DUR_HI  = 3;
  localparam int DUR_LO  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  function automatic logic [7:0] ent(
    input logic [3:0] code,
    input logic [3:0] dur
  );
    return {code, dur};
  endfunction

  function automatic logic [3:0] note_vis(input logic [3:0] code);
    return (code >= NOTE_C4 && code <= NOTE_C5) ? code : NOTE_NONE;
  endfunction

  function automatic logic [7:0] note_led(input logic [3:0] code);
    logic [7:0] led;
    led = 8'h00;
    unique case (1'b1)
      (code == NOTE_C4): led = 8'h80;
      (code == NOTE_D):  led = 8'h40;
      (code == NOTE_E):  led = 8'h20;
      (code == NOTE_F):  led = 8'h10;
      (code == NOTE_G):  led = 8'h08;
      (code == NOTE_A):  led = 8'h04;
      (code == NOTE_B):  led = 8'h02;
      (code == NOTE_C5): led = 8'h01;
      default:           led = 8'h00;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: registered song table, one (note, duration) byte per entry.
// Unknown SONG_ID values read as an immediate end marker.
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int SONG_ID = 0
) (
  input  logic              CLK,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  int         a;
  logic [7:0] rom_q;

  assign a = int'(addr);

  always_comb begin
    rom_q = 8'h00;
    case (SONG_ID)
      0: case (a)
        0: rom_q = ent(NOTE_E, 4'd1);
        1: rom_q = ent(NOTE_E, 4'd1);
        2: rom_q = ent(NOTE_F, 4'd1);
        3: rom_q = ent(NOTE_G, 4'd1);
        4: rom_q = ent(NOTE_NONE, 4'd2);
        5: rom_q = ent(NOTE_C5, 4'd3);
        default: rom_q = 8'h00;
      endcase
      1: case (a)
        0:  rom_q = ent(NOTE_E, 4'd1);
        1:  rom_q = ent(NOTE_E, 4'd1);
        2:  rom_q = ent(NOTE_F, 4'd1);
        3:  rom_q = ent(NOTE_G, 4'd1);
        4:  rom_q = ent(NOTE_G, 4'd1);
        5:  rom_q = ent(NOTE_F, 4'd1);
        6:  rom_q = ent(NOTE_E, 4'd1);
        7:  rom_q = ent(NOTE_D, 4'd1);
        8:  rom_q = ent(NOTE_C4, 4'd1);
        9:  rom_q = ent(NOTE_C4, 4'd1);
        10: rom_q = ent(NOTE_D, 4'd1);
        11: rom_q = ent(NOTE_E, 4'd1);
        12: rom_q = ent(NOTE_E, 4'd2);
        13: rom_q = ent(NOTE_D, 4'd1);
        14: rom_q = ent(NOTE_D, 4'd2);
        default: rom_q = 8'h00;
      endcase
      2: case (a)
        0: rom_q = ent(NOTE_C4, 4'd3);
        1: rom_q = ent(NOTE_D, 4'd1);
        2: rom_q = ent(NOTE_E, 4'd3);
        3: rom_q = ent(NOTE_C4, 4'd1);
        4: rom_q = ent(NOTE_E, 4'd2);
        5: rom_q = ent(NOTE_C4, 4'd2);
        6: rom_q = ent(NOTE_E, 4'd4);
        default: rom_q = 8'h00;
      endcase
      default: rom_q = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    data <= rom_q;
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: ROM-driven autoplay engine for the piano note/LED mux.
// Define SONG_LOOP_EN to restart at entry 0 instead of stopping in DONE.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int SONG_ID = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       QUARTER_BEAT,
  input  logic       START,
  input  logic       STOP,
  output logic [3:0] note,
  output logic [7:0] Led,
  output logic       busy,
  output logic       done
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        beats_left;
  logic              last;
  logic [7:0]        rom_data;
  logic [3:0]        rom_code;
  logic [3:0]        rom_dur;
  logic              song_end;

  song_rom #(
    .ADDR_W (ADDR_W),
    .SONG_ID(SONG_ID)
  ) u_rom (
    .CLK (CLK),
    .addr(addr),
    .data(rom_data)
  );

  assign rom_code = rom_data[CODE_HI:CODE_LO];
  assign rom_dur  = rom_data[DUR_HI:DUR_LO];

  // End marker in LOAD, or final beat of the entry at the top address.
  assign song_end =
    (state == S_LOAD && rom_dur == 4'd0) ||
    (state == S_PLAY && QUARTER_BEAT &&
     beats_left == 4'd1 && last);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      addr       <= '0;
      beats_left <= '0;
      last       <= 1'b0;
      note       <= NOTE_NONE;
      Led        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (STOP) begin
      state <= S_IDLE;
      note  <= NOTE_NONE;
      Led   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (START) begin
      state <= S_FETCH;
      addr  <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (song_end) begin
`ifdef SONG_LOOP_EN
      state <= S_FETCH;
      addr  <= '0;
`else
      state <= S_DONE;
      note  <= NOTE_NONE;
      Led   <= '0;
      busy  <= 1'b0;
      done  <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          note <= NOTE_NONE;
          Led  <= '0;
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          note       <= note_vis(rom_code);
          Led        <= note_led(rom_code);
          beats_left <= rom_dur;
          last       <= (addr == ADDR_MAX);
          state      <= S_PLAY;
        end
        S_PLAY: begin
          if (QUARTER_BEAT) begin
            beats_left <= beats_left - 4'd1;
            if (beats_left == 4'd1) begin
              addr  <= addr + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed test of song_sequencer (SONG_ID 0)
// against a song-level timeline model plus literal note/LED checks.
module tb_song_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       QUARTER_BEAT;
  logic       START;
  logic       STOP;
  logic [3:0] note;
  logic [7:0] Led;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int tcnt  = 0;

  always #5 CLK = ~CLK;

  song_sequencer #(
    .ADDR_W (5),
    .SONG_ID(0)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .QUARTER_BEAT(QUARTER_BEAT),
    .START       (START),
    .STOP        (STOP),
    .note        (note),
    .Led         (Led),
    .busy        (busy),
    .done        (done)
  );

  // model: song table, position, beats left, cycles until next entry shows
  logic [7:0] mrom [32];
  int         ph;
  int         idx;
  int         left;
  int         gap;
  logic [3:0] m_note;
  logic [7:0] m_led;
  logic       chk_en  = 1'b0;
  logic       log_en  = 1'b0;
  logic       done_seen = 1'b0;
  logic [3:0] nlog [$];
  logic [7:0] llog [$];

  function automatic logic [3:0] vis(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd8) ? c : 4'd0;
  endfunction

  function automatic logic [7:0] ledof(input logic [3:0] c);
    logic [7:0] v;
    v = 8'h80;
    return (c >= 4'd1 && c <= 4'd8) ? (v >> (c - 4'd1)) : 8'h00;
  endfunction

  task automatic end_song();
`ifdef SONG_LOOP_EN
    idx = 0;
    gap = 2;
`else
    ph     = 2;
    m_note = 4'd0;
    m_led  = 8'h00;
`endif
  endtask

  task automatic model_step();
    logic [7:0] e;
    if (RESET || STOP) begin
      ph = 0; gap = 0; m_note = 4'd0; m_led = 8'h00;
    end else if (START) begin
      ph = 1; idx = 0; gap = 2;
    end else if (ph == 1) begin
      if (gap > 0) begin
        gap--;
        if (gap == 0) begin
          e = mrom[idx];
          if (e[3:0] == 4'd0) end_song();
          else begin
            m_note = vis(e[7:4]);
            m_led  = ledof(e[7:4]);
            left   = int'(e[3:0]);
          end
        end
      end else if (QUARTER_BEAT) begin
        left--;
        if (left == 0) begin
          if (idx == 31) end_song();
          else begin idx++; gap = 2; end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mrom[i] = 8'h00;
    mrom[0] = 8'h31; mrom[1] = 8'h31; mrom[2] = 8'h41;
    mrom[3] = 8'h51; mrom[4] = 8'h02; mrom[5] = 8'h83;
    ph = 0; idx = 0; left = 0; gap = 0;
    m_note = 4'd0; m_led = 8'h00;
    forever begin
      @(posedge CLK);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        total++;
        if ({note, Led, busy, done} !==
            {m_note, m_led, ph == 1, ph == 2}) begin
          bad++;
          $display("FAIL cycle t=%0t: note=%0d Led=%h busy=%b done=%b want note=%0d Led=%h busy=%b done=%b",
                   $time, note, Led, busy, done, m_note, m_led, ph == 1, ph == 2);
        end
        if (done) done_seen = 1'b1;
        if (log_en && QUARTER_BEAT && ph == 1) begin
          nlog.push_back(note);
          llog.push_back(Led);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic p);
    @(posedge CLK);
    #1;
    tcnt++;
    QUARTER_BEAT = (tcnt % 20 == 0);
    START = s;
    STOP  = p;
  endtask

  task automatic align();
    while (tcnt % 20 != 0) step(1'b0, 1'b0);
  endtask

  task automatic clr_log();
    nlog.delete();
    llog.delete();
  endtask

  logic [3:0] pat [9] = '{4'd3, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd8, 4'd8, 4'd8};
  logic [3:0] rpat [10] = '{4'd0, 4'd0, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd8, 4'd8, 4'd8};
  int nexp;
  int waited;

  initial begin
    RESET = 1'b1; START = 1'b0; STOP = 1'b0; QUARTER_BEAT = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    chk("reset", {note, Led, busy, done}, 14'h0);
    RESET = 1'b0;
    chk_en = 1'b1;

    // full song with a tick every 20 cycles
    align();
    step(1'b1, 1'b0);
    clr_log();
    log_en = 1'b1;
`ifdef SONG_LOOP_EN
    repeat (740) step(1'b0, 1'b0);
    nexp = 36;
`else
    repeat (200) step(1'b0, 1'b0);
    nexp = 9;
`endif
    log_en = 1'b0;
    chk("tick_count", nlog.size() >= nexp, 1);
    if (nlog.size() >= nexp) begin
      for (int i = 0; i < nexp; i++) chk("seq_note", nlog[i], pat[i % 9]);
      chk("led_E", llog[0], 8'h20);
      chk("led_C5", llog[8], 8'h01);
      chk("led_rest", llog[4], 8'h00);
    end
`ifdef SONG_LOOP_EN
    chk("loop_no_done", done_seen, 0);
    chk("loop_busy", busy, 1);
`else
    chk("end_state", {note, Led, busy, done}, 14'h1);
`endif

    // STOP during C5, then replay
    align();
    step(1'b1, 1'b0);
    waited = 0;
    while (m_note != 4'd8 && waited < 300) begin
      step(1'b0, 1'b0);
      waited++;
    end
    chk("wait_c5", waited < 300, 1);
    repeat (3) step(1'b0, 1'b0);
    chk("c5_playing", {note, Led}, 12'h801);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("stop_state", {note, Led, busy, done}, 14'h0);
    align();
    step(1'b1, 1'b0);
    clr_log();
    log_en = 1'b1;
    repeat (25) step(1'b0, 1'b0);
    log_en = 1'b0;
    chk("replay_first", nlog.size() >= 1 ? nlog[0] : 4'hf, 4'd3);

    // START and STOP together while playing
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("start_stop", {note, Led, busy, done}, 14'h0);

    // rest code 12 with duration 2 substituted for entry 0
    align();
    force dut.rom_data = 8'hC2;
    mrom[0] = 8'hC2;
    step(1'b1, 1'b0);
    clr_log();
    log_en = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    release dut.rom_data;
    mrom[0] = 8'h31;
    repeat (220) step(1'b0, 1'b0);
    log_en = 1'b0;
    chk("rest_ticks", nlog.size() >= 10, 1);
    if (nlog.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk("rest_seq", nlog[i], rpat[i]);
      chk("rest_led", llog[0], 8'h00);
      chk("rest_led2", llog[1], 8'h00);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
